// File: rtl/fir_coeff_ctrl_if.sv
// Host/FIR-side bundle for the coefficient controller: host write port,
// commit handshake, sample strobe and the active coefficient bus.
interface fir_coeff_ctrl_if #(
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int ADDR_WIDTH  = 2
);
  logic                            wr_valid;
  logic                            wr_ready;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [COEFF_WIDTH-1:0]          wr_data;
  logic                            commit;
  logic                            commit_ack;
  logic                            commit_drop;
  logic                            sample_en;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] coeff;
  logic                            bank_id;
  logic                            out_valid;
  logic                            busy;

  // Host / FIR side
  modport master (
    output wr_valid, wr_addr, wr_data, commit, sample_en,
    input  wr_ready, commit_ack, commit_drop, coeff, bank_id, out_valid, busy
  );

  // Controller side
  modport slave (
    input  wr_valid, wr_addr, wr_data, commit, sample_en,
    output wr_ready, commit_ack, commit_drop, coeff, bank_id, out_valid, busy
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: host writes a shadow bank, a commit copies it
// into the active bank on the next sample boundary, and out_valid is masked
// until the tap pipeline has refilled with samples under the new set.
module fir_coeff_ctrl #(
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  fir_coeff_ctrl_if.slave   bus
);

  localparam int              CNT_W    = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [COEFF_WIDTH-1:0] shadow_r [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] active_r [NUM_TAPS];
  logic                   bank_id_r;
  logic                   out_valid_r;
  logic                   commit_ack_r;
  logic                   commit_drop_r;

  logic                   busy_s;
  logic                   wr_ready_s;
  logic                   wr_acc_s;
  logic                   xfer_s;
  logic                   flush_step_s;
  logic                   flush_done_s;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] coeff_s;

  // State register; reset lands in FLUSH so the pipeline refills first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FLUSH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.commit) state_nxt_s = ST_PENDING;
        else            state_nxt_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (bus.sample_en) state_nxt_s = ST_FLUSH;
        else               state_nxt_s = ST_PENDING;
      end
      ST_FLUSH: begin
        if (bus.sample_en && (cnt_r == CNT_LAST)) state_nxt_s = ST_IDLE;
        else                                      state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_FLUSH;
    endcase
  end

  // State-decoded controls: write gating, transfer and flush strobes
  always_comb begin
    busy_s       = 1'b1;
    wr_ready_s   = 1'b1;
    xfer_s       = 1'b0;
    flush_step_s = 1'b0;
    flush_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s     = 1'b0;
        wr_ready_s = 1'b1;
      end
      ST_PENDING: begin
        busy_s     = 1'b1;
        wr_ready_s = 1'b0;
        xfer_s     = bus.sample_en;
      end
      ST_FLUSH: begin
        busy_s       = 1'b1;
        wr_ready_s   = 1'b1;
        flush_step_s = bus.sample_en;
        flush_done_s = bus.sample_en && (cnt_r == CNT_LAST);
      end
      default: begin
        busy_s     = 1'b1;
        wr_ready_s = 1'b1;
      end
    endcase
  end

  assign wr_acc_s = bus.wr_valid & wr_ready_s;

  // Shadow bank: addresses beyond the last tap match no entry and are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) shadow_r[i] <= {COEFF_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (wr_acc_s && (bus.wr_addr == ADDR_WIDTH'(i))) shadow_r[i] <= bus.wr_data;
        else                                            shadow_r[i] <= shadow_r[i];
      end
    end
  end

  // Active bank: whole-bank copy on the sample boundary; shadow is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) active_r[i] <= {COEFF_WIDTH{1'b0}};
    end else if (xfer_s) begin
      active_r <= shadow_r;
    end else begin
      active_r <= active_r;
    end
  end

  // Refill counter: counts samples taken under the new coefficient set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (xfer_s || flush_done_s) begin
      cnt_r <= CNT_ZERO;
    end else if (flush_step_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered status: validity mask, bank toggle and one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      bank_id_r     <= 1'b0;
      commit_ack_r  <= 1'b0;
      commit_drop_r <= 1'b0;
    end else begin
      if (xfer_s)            out_valid_r <= 1'b0;
      else if (flush_done_s) out_valid_r <= 1'b1;
      else                   out_valid_r <= out_valid_r;
      if (xfer_s) bank_id_r <= ~bank_id_r;
      else        bank_id_r <= bank_id_r;
      commit_ack_r  <= xfer_s;
      commit_drop_r <= bus.commit && (state_r != ST_IDLE);
    end
  end

  // Flatten the active bank onto the FIR coefficient bus, tap 0 in the LSBs
  always_comb begin
    coeff_s = {(COEFF_WIDTH*NUM_TAPS){1'b0}};
    for (int i = 0; i < NUM_TAPS; i++) coeff_s[COEFF_WIDTH*i +: COEFF_WIDTH] = active_r[i];
  end

  assign bus.coeff       = coeff_s;
  assign bus.bank_id     = bank_id_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.commit_ack  = commit_ack_r;
  assign bus.commit_drop = commit_drop_r;
  assign bus.busy        = busy_s;
  assign bus.wr_ready    = wr_ready_s;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl with hand-computed expectations.
module tb_fir_coeff_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ack_cnt;
  int   drop_cnt;
  int   ack_snap;

  fir_coeff_ctrl_if #(.COEFF_WIDTH(8), .NUM_TAPS(4), .ADDR_WIDTH(2)) bus ();

  fir_coeff_ctrl #(.COEFF_WIDTH(8), .NUM_TAPS(4), .ADDR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count commit pulses, sampled between edges
  always @(negedge clk) begin
    if (!rst && bus.commit_ack)  ack_cnt++;
    if (!rst && bus.commit_drop) drop_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
  endtask

  // sample_en on every third cycle
  task automatic strobe3();
    cyc();
    cyc();
    bus.sample_en = 1'b1;
    cyc();
    bus.sample_en = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; ack_cnt = 0; drop_cnt = 0; ack_snap = 0;
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00;
    bus.commit = 1'b0; bus.sample_en = 1'b0;
    repeat (3) cyc();

    // Reset values
    check_val("rst_coeff",    bus.coeff,       32'h0);
    check_val("rst_bank",     bus.bank_id,     32'd0);
    check_val("rst_valid",    bus.out_valid,   32'd0);
    check_val("rst_ack",      bus.commit_ack,  32'd0);
    check_val("rst_drop",     bus.commit_drop, 32'd0);
    check_val("rst_busy",     bus.busy,        32'd1);
    check_val("rst_wr_ready", bus.wr_ready,    32'd1);
    rst = 1'b0;

    // Initial refill: four strobes
    for (int i = 0; i < 4; i++) begin
      bus.sample_en = 1'b1;
      cyc();
      bus.sample_en = 1'b0;
      if (i == 2) begin
        check_val("init_valid3", bus.out_valid, 32'd0);
        check_val("init_busy3",  bus.busy,      32'd1);
      end
      cyc();
    end
    check_val("init_valid4", bus.out_valid, 32'd1);
    check_val("init_busy4",  bus.busy,      32'd0);

    // Load and commit
    wr(2'd0, 8'h01); wr(2'd1, 8'h02); wr(2'd2, 8'hFE); wr(2'd3, 8'h7F);
    check_val("load_coeff_pre", bus.coeff, 32'h0);
    pulse_commit();
    check_val("load_busy_pend", bus.busy,     32'd1);
    check_val("load_wr_ready",  bus.wr_ready, 32'd0);
    cyc(); cyc();
    check_val("load_coeff_wait", bus.coeff, 32'h0);
    bus.sample_en = 1'b1;
    cyc();
    bus.sample_en = 1'b0;
    check_val("load_coeff", bus.coeff,      32'h7FFE0201);
    check_val("load_ack",   bus.commit_ack, 32'd1);
    check_val("load_bank",  bus.bank_id,    32'd1);
    check_val("load_valid", bus.out_valid,  32'd0);
    cyc();
    check_val("load_ack_end", bus.commit_ack, 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobe3();
      check_val("load_flush_valid", bus.out_valid, 32'd0);
    end
    strobe3();
    check_val("load_valid_up", bus.out_valid, 32'd1);
    check_val("load_ack_cnt",  ack_cnt,       32'd1);

    // Incremental edit of tap 2
    wr(2'd2, 8'h10);
    pulse_commit();
    strobe3();
    check_val("incr_coeff", bus.coeff,   32'h7F100201);
    check_val("incr_bank",  bus.bank_id, 32'd0);
    for (int i = 0; i < 4; i++) strobe3();
    check_val("incr_valid", bus.out_valid, 32'd1);

    // Back-pressure: write held off while PENDING, accepted after transfer
    pulse_commit();
    bus.wr_valid = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 8'hAA;
    cyc();
    check_val("bp_wr_ready", bus.wr_ready, 32'd0);
    bus.sample_en = 1'b1;
    cyc();
    bus.sample_en = 1'b0;
    check_val("bp_coeff",    bus.coeff,    32'h7F100201);
    check_val("bp_bank",     bus.bank_id,  32'd1);
    check_val("bp_ready_up", bus.wr_ready, 32'd1);
    cyc();
    bus.wr_valid = 1'b0;

    // Dropped commit during FLUSH
    pulse_commit();
    check_val("drop_pulse", bus.commit_drop, 32'd1);
    check_val("drop_noack", bus.commit_ack,  32'd0);
    cyc();
    check_val("drop_end",  bus.commit_drop, 32'd0);
    check_val("drop_bank", bus.bank_id,     32'd1);
    for (int i = 0; i < 4; i++) strobe3();
    check_val("drop_valid",   bus.out_valid, 32'd1);
    check_val("drop_cnt",     drop_cnt,      32'd1);
    check_val("drop_ack_cnt", ack_cnt,       32'd3);

    // Commit with sample_en in the same cycle, then sample_en held high
    bus.commit = 1'b1; bus.sample_en = 1'b1;
    cyc();
    bus.commit = 1'b0;
    check_val("same_coeff", bus.coeff, 32'h7F100201);
    check_val("same_busy",  bus.busy,  32'd1);
    check_val("same_ack",   bus.commit_ack, 32'd0);
    cyc();
    check_val("cont_coeff", bus.coeff,      32'h7F1002AA);
    check_val("cont_ack",   bus.commit_ack, 32'd1);
    check_val("cont_bank",  bus.bank_id,    32'd0);
    repeat (3) cyc();
    check_val("cont_valid3", bus.out_valid, 32'd0);
    cyc();
    bus.sample_en = 1'b0;
    check_val("cont_valid4", bus.out_valid, 32'd1);
    check_val("cont_busy4",  bus.busy,      32'd0);
    check_val("cont_ack_cnt", ack_cnt,      32'd4);

    // Reset during PENDING
    pulse_commit();
    check_val("rp_busy", bus.busy, 32'd1);
    ack_snap = ack_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_val("rp_coeff", bus.coeff,     32'h0);
    check_val("rp_valid", bus.out_valid, 32'd0);
    check_val("rp_busy2", bus.busy,      32'd1);
    check_val("rp_bank",  bus.bank_id,   32'd0);
    cyc(); cyc();
    rst = 1'b0;
    bus.sample_en = 1'b1;
    cyc();
    bus.sample_en = 1'b0;
    check_val("rp_coeff2",    bus.coeff,      32'h0);
    check_val("rp_ack",       bus.commit_ack, 32'd0);
    check_val("rp_flush",     bus.busy,       32'd1);
    cyc();
    check_val("rp_ack_cnt",   ack_cnt,        ack_snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient configuration and sequencing controller for the `fir` filter. A host writes tap coefficients into a shadow bank. On commit, the block copies the shadow bank into the active bank driving the FIR `coeff` bus, exactly on a sample boundary. It then masks FIR output validity until the tap pipeline has refilled with samples filtered by the new coefficient set.

## Interface

- `COEFF_WIDTH`, 8, width of one coefficient.
- `NUM_TAPS`, 4, number of taps; must be ≥2.
- `ADDR_WIDTH`, 2, tap address width; must satisfy 2^ADDR_WIDTH ≥ NUM_TAPS.

Ports:

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  host coefficient write request.
- `wr_ready`  out  1  shadow bank accepts writes.
- `wr_addr`  in  ADDR_WIDTH  tap index.
- `wr_data`  in  COEFF_WIDTH  coefficient value, two's complement.
- `commit`  in  1  request shadow→active transfer; level sampled each cycle.
- `commit_ack`  out  1  one-cycle pulse, cycle after the transfer edge.
- `commit_drop`  out  1  one-cycle pulse, commit seen while not IDLE.
- `sample_en`  in  1  strobe marking a cycle in which the FIR consumes a new sample.
- `coeff`  out  COEFF_WIDTH*NUM_TAPS  active bank; tap i at [COEFF_WIDTH*i +: COEFF_WIDTH].
- `bank_id`  out  1  toggles on every transfer.
- `out_valid`  out  1  FIR output qualified as filtered by a single coefficient set.
- `busy`  out  1  high in PENDING or FLUSH.

## Operation

- Storage:
  - Two register arrays, `shadow[NUM_TAPS]` and `active[NUM_TAPS]`.
  - `coeff` is driven directly from `active` registers; no combinational path from the host.
- Write:
  - A write is accepted when `wr_valid && wr_ready`; `shadow[wr_addr]` updates at that edge.
  - `wr_addr ≥ NUM_TAPS` is accepted and discarded.
  - `wr_ready = (state != PENDING)`.
- Transfer is a copy: `active <= shadow`, and `shadow` is unchanged. Incremental edits of single taps therefore work across commits.
- FSM states: IDLE, PENDING, FLUSH. Reset state is FLUSH with `cnt = 0`.
  - IDLE: `commit` → PENDING. `sample_en` is ignored.
  - PENDING: `sample_en` → transfer at the same edge, then FLUSH with `cnt <= 0`, `out_valid <= 0`, `bank_id` toggles, and `commit_ack` is high the next cycle.
  - FLUSH: each `sample_en` increments `cnt`. A `sample_en` with `cnt == NUM_TAPS-1` → IDLE with `out_valid <= 1`.
- `commit` in PENDING or FLUSH is dropped and pulses `commit_drop` the next cycle. It is not queued.
- Arithmetic: `cnt` is $clog2(NUM_TAPS) bits and never wraps, because it leaves FLUSH at NUM_TAPS-1.

## Timing

- Reset values:
  - All `shadow` and `active` entries are 0, so `coeff = 0`.
  - `bank_id = 0`, `out_valid = 0`, `commit_ack = 0`, `commit_drop = 0`.
  - `busy = 1` (FLUSH), `wr_ready = 1`.
- Write latency: the shadow entry is visible internally 1 cycle after acceptance. It does not reach `coeff` until a transfer.
- Commit latency:
  - The transfer happens on the first `sample_en` strictly after the cycle in which `commit` is sampled in IDLE.
  - A `sample_en` in the same cycle as `commit` does not trigger the transfer.
- A write and `commit` in the same IDLE cycle: the write is included in the transfer.
- `out_valid` falls the cycle after the transfer edge. It rises the cycle after the NUM_TAPS-th `sample_en` following the transfer.
- `sample_en` held high continuously: the transfer happens in the first PENDING cycle, and FLUSH lasts exactly NUM_TAPS cycles.
- `rst` mid-PENDING or mid-FLUSH: all state returns to reset values immediately. A pending commit is lost and no `commit_ack` is issued.
- `busy` and `wr_ready` are registered-state decodes only.

## Test plan

- **Reset:** assert `rst` mid-cycle → immediately `coeff = 32'h0`, `out_valid = 0`, `busy = 1`. After 4 `sample_en` strobes → `out_valid = 1`, `busy = 0`.
- **Load and commit:**
  - Stimulus: write taps 0..3 = 8'h01, 8'h02, 8'hFE, 8'h7F; pulse `commit`; `sample_en` every 3rd cycle.
  - Response: `coeff` goes to 32'h7FFE0201 only on the first PENDING `sample_en` edge; `commit_ack` is a single pulse; `bank_id = 1`.
  - Response: `out_valid` stays low for exactly 4 `sample_en` strobes, then goes high.
- **Incremental edit:** after the previous scenario, write tap 2 = 8'h10 and commit → `coeff = 32'h7F100201`.
- **Back-pressure:** in PENDING, `wr_valid = 1` with tap 0 = 8'hAA → `wr_ready = 0`, shadow unchanged. After the transfer, the write is accepted.
- **Dropped commit:** `commit` during FLUSH → `commit_drop` pulses once, with no second `commit_ack` and no `bank_id` toggle.
- **Reset during PENDING:** commit, then assert `rst` before any `sample_en` → `coeff = 0`, `commit_ack` never asserted, state FLUSH.
